// File: rtl/i2c_frame_counter.sv
// ---------------------------------------------------------------------------
// i2c_frame_counter
//   Single-clock I2C subordinate bus framer. Raw SCL/SDA are synchronised and
//   glitch-filtered on i_clk, START / repeated START / STOP are detected on the
//   filtered lines, and each frame is tracked as DATA_BITS data bits plus one
//   ACK slot. Completed bytes are presented on o_data_byte and counted per
//   transaction.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | bus free, SCL edges ignored, waiting for START
//   DATA  | shifting data bits on SCL rises, bit count 0..DATA_BITS
//   ACK   | ACK clock of the frame; SCL rise samples ACK, SCL fall ends frame
//
// Ports
//   i_clk        system clock, all logic on posedge
//   i_rst        synchronous active-high reset
//   i_enable     0 holds the framer cleared, same effect as reset
//   i_scl_in     raw SCL pin
//   i_sda_in     raw SDA pin
//   o_start_det  1-cycle pulse on START or repeated START
//   o_stop_det   1-cycle pulse on STOP
//   o_busy       high from START until STOP
//   o_bit_cnt    data bits sampled in the current frame, 0..DATA_BITS
//   o_ack_slot   high during the ACK clock of the frame
//   o_byte_done  1-cycle pulse when a full byte has been received
//   o_data_byte  last completed byte, MSB first
//   o_ack_bit    SDA sampled on the ACK-slot SCL rise (0 = ACK)
//   o_ack_valid  1-cycle pulse when o_ack_bit updates
//   o_byte_cnt   bytes completed since the last START, wraps
// ---------------------------------------------------------------------------
module i2c_frame_counter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int DATA_BITS   = 8,
   parameter int BYTE_CNT_W  = 8
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_enable,
   input  logic                           i_scl_in,
   input  logic                           i_sda_in,
   output logic                           o_start_det,
   output logic                           o_stop_det,
   output logic                           o_busy,
   output logic [$clog2(DATA_BITS+1)-1:0] o_bit_cnt,
   output logic                           o_ack_slot,
   output logic                           o_byte_done,
   output logic [DATA_BITS-1:0]           o_data_byte,
   output logic                           o_ack_bit,
   output logic                           o_ack_valid,
   output logic [BYTE_CNT_W-1:0]          o_byte_cnt
);

   localparam int BCW    = $clog2(DATA_BITS + 1);
   localparam int FCNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
   localparam logic [BCW-1:0]    BIT_LAST  = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0]    BIT_FULL  = BCW'(DATA_BITS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   // index 0 = SCL, index 1 = SDA
   logic                          w_clr;
   logic [1:0]                    w_raw;
   logic [1:0][SYNC_STAGES-1:0]   r_sync;
   logic [1:0][FCNT_W-1:0]        r_fcnt;
   logic [1:0]                    r_filt;
   logic [1:0]                    r_prev;

   logic                          w_scl_rise;
   logic                          w_scl_fall;
   logic                          w_scl_steady_hi;
   logic                          w_start;
   logic                          w_stop;
   logic                          w_sda;
   logic [DATA_BITS-1:0]          w_shift_next;

   state_t                        r_state;
   logic [DATA_BITS-2:0]          r_shift;

   assign w_clr = i_rst | ~i_enable;
   assign w_raw = {i_sda_in, i_scl_in};

   // Synchroniser and filter preload high so the bus looks idle after clear,
   // which keeps a spurious START from appearing when clear releases.
   always_ff @(posedge i_clk) begin
      if (w_clr) begin
         r_sync <= '1;
         r_fcnt <= '0;
         r_filt <= 2'b11;
         r_prev <= 2'b11;
      end else begin
         for (int i = 0; i < 2; i++) begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
            if (r_sync[i][SYNC_STAGES-1] != r_filt[i]) begin
               if (r_fcnt[i] == FCNT_LAST) begin
                  r_filt[i] <= r_sync[i][SYNC_STAGES-1];
                  r_fcnt[i] <= '0;
               end else begin
                  r_fcnt[i] <= r_fcnt[i] + 1'b1;
               end
            end else begin
               r_fcnt[i] <= '0;
            end
         end
         r_prev <= r_filt;
      end
   end

   assign w_sda           = r_filt[1];
   assign w_scl_rise      = r_filt[0] & ~r_prev[0];
   assign w_scl_fall      = ~r_filt[0] & r_prev[0];
   // SCL must be high now and before, so a simultaneous SCL/SDA change is data.
   assign w_scl_steady_hi = r_filt[0] & r_prev[0];
   assign w_start         = w_scl_steady_hi & r_prev[1] & ~r_filt[1];
   assign w_stop          = w_scl_steady_hi & ~r_prev[1] & r_filt[1];
   assign w_shift_next    = {r_shift, w_sda};

   always_ff @(posedge i_clk) begin
      if (w_clr) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         o_start_det <= 1'b0;
         o_stop_det  <= 1'b0;
         o_busy      <= 1'b0;
         o_bit_cnt   <= '0;
         o_ack_slot  <= 1'b0;
         o_byte_done <= 1'b0;
         o_data_byte <= '0;
         o_ack_bit   <= 1'b0;
         o_ack_valid <= 1'b0;
         o_byte_cnt  <= '0;
      end else begin
         o_start_det <= 1'b0;
         o_stop_det  <= 1'b0;
         o_byte_done <= 1'b0;
         o_ack_valid <= 1'b0;
         if (w_stop) begin
            // partial byte is dropped; data, count and ack keep their values
            o_stop_det <= 1'b1;
            r_state    <= S_IDLE;
            o_busy     <= 1'b0;
            o_bit_cnt  <= '0;
            o_ack_slot <= 1'b0;
         end else if (w_start) begin
            o_start_det <= 1'b1;
            r_state     <= S_DATA;
            o_busy      <= 1'b1;
            o_bit_cnt   <= '0;
            o_byte_cnt  <= '0;
            o_ack_slot  <= 1'b0;
            r_shift     <= '0;
         end else begin
            case (r_state)
               S_DATA: begin
                  if (w_scl_rise && (o_bit_cnt != BIT_FULL)) begin
                     r_shift   <= w_shift_next[DATA_BITS-2:0];
                     o_bit_cnt <= o_bit_cnt + 1'b1;
                     if (o_bit_cnt == BIT_LAST) begin
                        o_data_byte <= w_shift_next;
                        o_byte_done <= 1'b1;
                        o_byte_cnt  <= o_byte_cnt + 1'b1;
                     end
                  end else if (w_scl_fall && (o_bit_cnt == BIT_FULL)) begin
                     r_state    <= S_ACK;
                     o_ack_slot <= 1'b1;
                  end
               end
               S_ACK: begin
                  if (w_scl_rise) begin
                     o_ack_bit   <= w_sda;
                     o_ack_valid <= 1'b1;
                  end else if (w_scl_fall) begin
                     r_state    <= S_DATA;
                     o_bit_cnt  <= '0;
                     o_ack_slot <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
